correlator_core: RTL and testbench

CORRELATOR_CORE -- requirements
Module: correlator_core

---
 rtl/correlator_core.sv | 243 ++++++++++++++++++++++++
 tb/tb_correlator_core.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/correlator_core.sv
// correlator_core: pulse cross/auto correlator.
// Detector pulses are synchronized and pushed down a tapped delay chain.
// Every lag of every input pair, plus the rising edges of each input, is
// counted over a frame of integration_len enabled cycles. At frame end the
// counters are snapshotted and streamed out as a header word followed by
// the cross counters and then the auto counters.
module correlator_core #(
   parameter int NUM_INPUTS = 4,
   parameter int MAX_DELAY  = 21,
   parameter int RESOLUTION = 16,
   parameter int SATURATE   = 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [NUM_INPUTS-1:0] pulse_in,
   input  logic                  enable,
   input  logic [31:0]           integration_len,
   output logic [RESOLUTION-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_last,
   output logic                  overrun
);
   localparam int DELAY_LINES = MAX_DELAY | 1;
   localparam int NC          = NUM_INPUTS * (NUM_INPUTS - 1) / 2;
   localparam int NUM_CROSS   = NC * DELAY_LINES;
   localparam int NUM_WORDS   = NUM_CROSS + NUM_INPUTS;
   localparam int IDX_W       = $clog2(NUM_WORDS);
   localparam logic [RESOLUTION-1:0] CNT_MAX = {RESOLUTION{1'b1}};
   localparam logic SAT_EN    = (SATURATE != 0);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HEADER = 2'd1,
      DATA   = 2'd2
   } state_t;

   // One counter step: hold when idle, stick at the top in saturating mode.
   function automatic logic [RESOLUTION-1:0] bump(input logic [RESOLUTION-1:0] value,
                                                  input logic                  step);
      logic [RESOLUTION-1:0] result;
      if (!step) begin
         result = value;
      end else if (SAT_EN && (value == CNT_MAX)) begin
         result = value;
      end else begin
         result = value + {{(RESOLUTION-1){1'b0}}, 1'b1};
      end
      return result;
   endfunction

   logic [NUM_INPUTS-1:0] sync_meta;
   logic [NUM_INPUTS-1:0] taps [DELAY_LINES];
   logic [NUM_INPUTS-1:0] sync_prev;
   logic [NUM_WORDS-1:0]  inc;
   logic [RESOLUTION-1:0] cnt [NUM_WORDS];
   logic [RESOLUTION-1:0] cnt_next [NUM_WORDS];
   logic [RESOLUTION-1:0] shadow [NUM_WORDS];
   logic                  sat_flag;
   logic                  sat_hit;
   logic                  sat_any;
   logic [31:0]           timer;
   logic [31:0]           len_latched;
   logic [31:0]           eff_len;
   logic [31:0]           frame_len;
   logic                  frame_end;
   logic                  snapshot;
   logic [15:0]           frame_count;
   logic [15:0]           frame_count_inc;
   logic [RESOLUTION-2:0] header_count;
   logic [RESOLUTION-1:0] header_word;
   state_t                state;
   state_t                state_next;
   logic [IDX_W-1:0]      idx;
   logic [IDX_W-1:0]      idx_next;
   logic                  valid_next;
   logic                  last_next;
   logic [RESOLUTION-1:0] data_next;
   logic                  xfer;

   // Two-flop synchronizer feeding tap 0 of the delay chain; sync_prev keeps the previous tap 0 for edge detection.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_meta <= '0;
         sync_prev <= '0;
         for (int l = 0; l < DELAY_LINES; l++) taps[l] <= '0;
      end else begin
         sync_meta <= pulse_in;
         taps[0]   <= sync_meta;
         for (int l = 1; l < DELAY_LINES; l++) taps[l] <= taps[l-1];
         sync_prev <= taps[0];
      end
   end

   // Increment requests: pair (a,b) at lag l pairs tap l of a with the mirrored tap of b.
   for (genvar ga = 0; ga < NUM_INPUTS; ga++) begin : g_a
      for (genvar gb = ga + 1; gb < NUM_INPUTS; gb++) begin : g_b
         localparam int PAIR = ga * (2 * NUM_INPUTS - ga - 1) / 2 + (gb - ga - 1);
         for (genvar gl = 0; gl < DELAY_LINES; gl++) begin : g_l
            assign inc[PAIR*DELAY_LINES + gl] = taps[gl][ga] & taps[DELAY_LINES-1-gl][gb];
         end
      end
      assign inc[NUM_CROSS + ga] = taps[0][ga] & ~sync_prev[ga];
   end

   // Next counter values and detection of an increment blocked by saturation.
   always_comb begin
      sat_hit = 1'b0;
      for (int k = 0; k < NUM_WORDS; k++) begin
         cnt_next[k] = bump(cnt[k], inc[k]);
         sat_hit     = sat_hit | (inc[k] & (cnt[k] == CNT_MAX));
      end
   end
   assign sat_any = SAT_EN & sat_hit;

   // Frame length is sampled on the first cycle of a frame; a zero length acts as one.
   assign eff_len   = (integration_len == 32'd0) ? 32'd1 : integration_len;
   assign frame_len = (timer == 32'd0) ? eff_len : len_latched;
   assign frame_end = (timer == frame_len - 32'd1);
   assign snapshot  = enable & frame_end;

   // Frame timer: counts enabled cycles and restarts after the last one.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         timer       <= 32'd0;
         len_latched <= 32'd0;
      end else if (!enable) begin
         timer       <= 32'd0;
         len_latched <= 32'd0;
      end else begin
         if (timer == 32'd0) len_latched <= eff_len;
         timer <= frame_end ? 32'd0 : timer + 32'd1;
      end
   end

   // Integration counters and per-frame saturation flag; cleared when disabled or at frame end.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < NUM_WORDS; k++) cnt[k] <= '0;
         sat_flag <= 1'b0;
      end else if (!enable || frame_end) begin
         for (int k = 0; k < NUM_WORDS; k++) cnt[k] <= '0;
         sat_flag <= 1'b0;
      end else begin
         for (int k = 0; k < NUM_WORDS; k++) cnt[k] <= cnt_next[k];
         sat_flag <= sat_flag | sat_any;
      end
   end

   assign frame_count_inc = frame_count + 16'd1;
   if (RESOLUTION - 1 <= 16) begin : g_hdr_narrow
      assign header_count = frame_count_inc[RESOLUTION-2:0];
   end else begin : g_hdr_wide
      assign header_count = {{(RESOLUTION-17){1'b0}}, frame_count_inc};
   end
   assign header_word = {sat_flag | sat_any, header_count};

   // Snapshot handling: load the shadow buffer only when the readout is idle, otherwise flag the drop.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         frame_count <= 16'd0;
         overrun     <= 1'b0;
         for (int k = 0; k < NUM_WORDS; k++) shadow[k] <= '0;
      end else if (snapshot) begin
         frame_count <= frame_count_inc;
         if (state == IDLE) begin
            for (int k = 0; k < NUM_WORDS; k++) shadow[k] <= cnt_next[k];
         end else begin
            overrun <= 1'b1;
         end
      end
   end

   assign xfer = out_valid & out_ready;

   // Readout next state and next output word; outputs hold while the sink stalls.
   always_comb begin
      state_next = state;
      idx_next   = idx;
      valid_next = 1'b0;
      last_next  = 1'b0;
      data_next  = '0;
      case (state)
         IDLE: begin
            if (snapshot) begin
               state_next = HEADER;
               valid_next = 1'b1;
               data_next  = header_word;
            end else begin
               state_next = IDLE;
            end
         end
         HEADER: begin
            valid_next = 1'b1;
            if (xfer) begin
               state_next = DATA;
               idx_next   = '0;
               data_next  = shadow[0];
               last_next  = 1'b0;
            end else begin
               data_next  = out_data;
               last_next  = out_last;
            end
         end
         DATA: begin
            if (xfer) begin
               if (idx == IDX_W'(NUM_WORDS - 1)) begin
                  state_next = IDLE;
               end else begin
                  idx_next   = idx + IDX_W'(1);
                  valid_next = 1'b1;
                  data_next  = shadow[idx_next];
                  last_next  = (idx_next == IDX_W'(NUM_WORDS - 1));
               end
            end else begin
               valid_next = 1'b1;
               data_next  = out_data;
               last_next  = out_last;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Readout state and registered stream outputs; reset aborts any frame in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         idx       <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_data  <= '0;
      end else begin
         state     <= state_next;
         idx       <= idx_next;
         out_valid <= valid_next;
         out_last  <= last_next;
         out_data  <= data_next;
      end
   end
endmodule

// File: tb/tb_correlator_core.sv
// Bench for correlator_core: a saturating and a wrapping instance share one
// stimulus stream; a frame-level reference model predicts every output word.
module tb_correlator_core;
   localparam int N    = 2;
   localparam int MD   = 2;
   localparam int DL   = MD | 1;
   localparam int RES  = 8;
   localparam int NC   = N * (N - 1) / 2;
   localparam int NW   = NC * DL + N;
   localparam int FW   = 1 + NW;
   localparam int CMAX = (1 << RES) - 1;
   localparam int LOG  = 8192;

   logic           clk = 1'b0;
   logic           reset_n;
   logic [N-1:0]   pulse_in;
   logic           enable;
   logic [31:0]    integration_len;
   logic           out_ready;
   logic [RES-1:0] data_s, data_w;
   logic           valid_s, valid_w, last_s, last_w, ovr_s, ovr_w;

   always #5 clk = ~clk;

   correlator_core #(.NUM_INPUTS(N), .MAX_DELAY(MD), .RESOLUTION(RES), .SATURATE(1)) dut_sat (
      .clk(clk), .reset_n(reset_n), .pulse_in(pulse_in), .enable(enable),
      .integration_len(integration_len), .out_data(data_s), .out_valid(valid_s),
      .out_ready(out_ready), .out_last(last_s), .overrun(ovr_s));

   correlator_core #(.NUM_INPUTS(N), .MAX_DELAY(MD), .RESOLUTION(RES), .SATURATE(0)) dut_wrap (
      .clk(clk), .reset_n(reset_n), .pulse_in(pulse_in), .enable(enable),
      .integration_len(integration_len), .out_data(data_w), .out_valid(valid_w),
      .out_ready(out_ready), .out_last(last_w), .overrun(ovr_w));

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference model state: input log per edge since reset, raw frame totals, expected words.
   logic [N-1:0]   p_log [LOG];
   int             ec;
   int             acc [NW];
   int             fr_pos, fr_len, frame_no, rem;
   bit             m_ovr;
   logic [RES-1:0] q_s[$];
   logic [RES-1:0] q_w[$];
   logic [RES-1:0] cap_s [FW];
   logic [RES-1:0] cap_w [FW];
   logic           cap_l [FW];
   int             got_n;

   // Synchronized input as seen by the counters at edge k (two-cycle synchronizer latency).
   function automatic logic [N-1:0] s_at(input int k);
      if (k < 2) return '0;
      return p_log[k-2];
   endfunction

   task automatic m_reset();
      ec = 0; fr_pos = 0; fr_len = 1; frame_no = 0; rem = 0; m_ovr = 1'b0;
      for (int w = 0; w < NW; w++) acc[w] = 0;
      q_s.delete(); q_w.delete();
   endtask

   task automatic model_edge();
      int rem0, w;
      bit sat;
      logic [N-1:0] ta, tb, cur, prv;
      logic [RES-1:0] h;
      if (!reset_n) return;
      if (ec >= LOG) begin
         $display("FAIL model_log: got %0d expected below %0d", ec, LOG);
         $fatal(1, "model log exhausted");
      end
      p_log[ec] = pulse_in;
      rem0 = rem;
      if (enable) begin
         if (fr_pos == 0) fr_len = (integration_len == 32'd0) ? 1 : int'(integration_len);
         w = 0;
         for (int a = 0; a < N; a++)
            for (int b = a + 1; b < N; b++)
               for (int l = 0; l < DL; l++) begin
                  ta = s_at(ec - l);
                  tb = s_at(ec - (DL - 1 - l));
                  if (ta[a] && tb[b]) acc[w]++;
                  w++;
               end
         cur = s_at(ec);
         prv = s_at(ec - 1);
         for (int i = 0; i < N; i++) if (cur[i] && !prv[i]) acc[NC*DL + i]++;
         if (fr_pos == fr_len - 1) begin
            frame_no = (frame_no + 1) % 65536;
            sat = 1'b0;
            for (int k = 0; k < NW; k++) if (acc[k] > CMAX) sat = 1'b1;
            if (rem0 == 0) begin
               h = RES'(frame_no % (1 << (RES - 1)));
               q_w.push_back(h);
               if (sat) h[RES-1] = 1'b1;
               q_s.push_back(h);
               for (int k = 0; k < NW; k++) begin
                  q_s.push_back(RES'((acc[k] > CMAX) ? CMAX : acc[k]));
                  q_w.push_back(RES'(acc[k] % (CMAX + 1)));
               end
               rem = FW;
            end else begin
               m_ovr = 1'b1;
            end
            for (int k = 0; k < NW; k++) acc[k] = 0;
            fr_pos = 0;
         end else begin
            fr_pos++;
         end
      end else begin
         fr_pos = 0;
         for (int k = 0; k < NW; k++) acc[k] = 0;
      end
      if (rem0 > 0 && out_ready) begin
         void'(q_s.pop_front());
         void'(q_w.pop_front());
         rem--;
      end
      ec++;
   endtask

   task automatic compare();
      if (!reset_n) begin
         check_val("rst_valid_s", valid_s, 32'd0);
         check_val("rst_valid_w", valid_w, 32'd0);
         check_val("rst_data_s", data_s, 32'd0);
         check_val("rst_data_w", data_w, 32'd0);
         check_val("rst_last_s", last_s, 32'd0);
         check_val("rst_last_w", last_w, 32'd0);
         check_val("rst_ovr_s", ovr_s, 32'd0);
         check_val("rst_ovr_w", ovr_w, 32'd0);
      end else begin
         check_val("valid_s", valid_s, rem > 0);
         check_val("valid_w", valid_w, rem > 0);
         if (rem > 0) begin
            check_val("data_s", data_s, q_s[0]);
            check_val("data_w", data_w, q_w[0]);
            check_val("last_s", last_s, rem == 1);
            check_val("last_w", last_w, rem == 1);
         end
         check_val("overrun_s", ovr_s, m_ovr);
         check_val("overrun_w", ovr_w, m_ovr);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      compare();
   endtask

   task automatic apply_reset();
      reset_n = 1'b0;
      m_reset();
      #1;
      compare();
      repeat (2) tick();
      reset_n = 1'b1;
   endtask

   // Capture the next complete frame from both instances, starting at a header.
   task automatic grab_frame(input int budget);
      bit started;
      got_n = 0;
      started = 1'b0;
      for (int c = 0; c < budget && got_n < FW; c++) begin
         if (!started && rem == FW) started = 1'b1;
         if (started && valid_s && out_ready) begin
            cap_s[got_n] = data_s;
            cap_w[got_n] = data_w;
            cap_l[got_n] = last_s;
            got_n++;
         end
         tick();
      end
      check_val("grab_words", got_n, FW);
   endtask

   initial begin
      logic [6:0] hc;
      int dens;
      reset_n = 1'b0; pulse_in = 2'b11; enable = 1'b1;
      integration_len = 32'd10; out_ready = 1'b1;
      m_reset();
      #1;
      compare();
      repeat (3) tick();
      reset_n = 1'b1;

      // Constant-high inputs: steady frames of three lag counts of 10, no edges.
      pulse_in = 2'b11; enable = 1'b1; integration_len = 32'd10; out_ready = 1'b1;
      repeat (30) tick();
      grab_frame(40);
      check_val("const_hdr_sat", cap_s[0][RES-1], 32'd0);
      for (int w = 1; w <= NC*DL; w++) check_val("const_tap", cap_s[w], 32'd10);
      check_val("const_auto0", cap_s[FW-2], 32'd0);
      check_val("const_auto1", cap_s[FW-1], 32'd0);
      check_val("const_last_end", cap_l[FW-1], 32'd1);
      check_val("const_last_hdr", cap_l[0], 32'd0);

      // Lag: input 0 then input 1 two cycles later lands on lag 2 only.
      apply_reset();
      pulse_in = 2'b00; enable = 1'b1; integration_len = 32'd40; out_ready = 1'b1;
      repeat (10) tick();
      pulse_in = 2'b01; tick();
      pulse_in = 2'b00; tick();
      pulse_in = 2'b10; tick();
      pulse_in = 2'b00;
      grab_frame(60);
      check_val("lag_tap0", cap_s[1], 32'd0);
      check_val("lag_tap1", cap_s[2], 32'd0);
      check_val("lag_tap2", cap_s[3], 32'd1);
      check_val("lag_auto0", cap_s[4], 32'd1);
      check_val("lag_auto1", cap_s[5], 32'd1);

      // Saturation versus wrap over a 300-cycle frame.
      apply_reset();
      pulse_in = 2'b11; enable = 1'b1; integration_len = 32'd300; out_ready = 1'b1;
      repeat (320) tick();
      grab_frame(400);
      check_val("sat_hdr_msb", cap_s[0][RES-1], 32'd1);
      check_val("wrap_hdr_msb", cap_w[0][RES-1], 32'd0);
      for (int w = 1; w <= NC*DL; w++) begin
         check_val("sat_tap", cap_s[w], 32'd255);
         check_val("wrap_tap", cap_w[w], 32'd44);
      end

      // Backpressure: held header, dropped frames, skipped frame numbers.
      apply_reset();
      enable = 1'b1; integration_len = 32'd10; out_ready = 1'b0;
      for (int c = 0; c < 32; c++) begin
         pulse_in = N'($urandom_range(0, 3));
         tick();
      end
      check_val("bp_overrun", ovr_s, 32'd1);
      out_ready = 1'b1;
      grab_frame(20);
      hc = cap_s[0][6:0];
      check_val("bp_hdr_first", hc, 32'd1);
      grab_frame(30);
      hc = cap_s[0][6:0];
      check_val("bp_hdr_next", hc, 32'd4);

      // Reset in the middle of the data words.
      apply_reset();
      pulse_in = 2'b11; enable = 1'b1; integration_len = 32'd10; out_ready = 1'b1;
      for (int c = 0; c < 40 && rem != 3; c++) tick();
      if (rem != 3) check_val("reach_data3", rem, 32'd3);
      reset_n = 1'b0;
      m_reset();
      #1;
      check_val("midrst_valid_s", valid_s, 32'd0);
      check_val("midrst_valid_w", valid_w, 32'd0);
      repeat (2) tick();
      reset_n = 1'b1;
      grab_frame(30);
      hc = cap_s[0][6:0];
      check_val("midrst_hdr", hc, 32'd1);

      // Randomized traffic: densities, enable gaps, length changes including 0, random ready.
      apply_reset();
      dens = 30;
      for (int c = 0; c < 3000; c++) begin
         if (c == 1500) apply_reset();
         if (c % 200 == 0) dens = $urandom_range(0, 100);
         for (int i = 0; i < N; i++) pulse_in[i] = ($urandom_range(0, 99) < dens);
         if (!enable) enable = ($urandom_range(0, 99) < 30);
         else         enable = ($urandom_range(0, 99) >= 1);
         if ($urandom_range(0, 49) == 0) integration_len = $urandom_range(0, 25);
         out_ready = ($urandom_range(0, 99) < 75);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
